// File: rtl/vga_timing.sv
// vga_timing: raster counters, sync pulses, blanking flags and start-of-frame strobe.
// Define VGA_TIMING_FRAME_CNT_EN to build the completed-frame counter.
module vga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        sof,
  output logic [15:0] frame_cnt
);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic        line_end;
  logic        frame_end;
  always_comb begin
    line_end  = hcount == H_LAST;
    frame_end = line_end && vcount == V_LAST;
    h_nxt     = line_end ? 11'd0 : hcount + 11'd1;
    v_nxt     = line_end ? (frame_end ? 10'd0 : vcount + 10'd1) : vcount;
  end
  // Flags decode the next position so they line up with the registered counters.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
      hblnk  <= 1'b0;
      vblnk  <= 1'b0;
      sof    <= 1'b0;
    end else if (ce) begin
      hcount <= h_nxt;
      vcount <= v_nxt;
      hsync  <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync  <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? SYNC_POL : ~SYNC_POL;
      hblnk  <= h_nxt >= H_ACT;
      vblnk  <= v_nxt >= V_ACT;
      sof    <= frame_end;
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) frame_cnt <= '0;
    else if (ce && frame_end) frame_cnt <= frame_cnt + 16'd1;
`else
  assign frame_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of vga_timing with full XGA lines and a shortened 15-line frame.
module tb_vga_timing;
  localparam int HT = 1344;
  localparam int VT = 15;
  localparam int VA = 4;
  localparam int VS0 = 7;
  localparam int VS1 = 12;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce = 1'b0;
  logic [10:0] hcount;
  logic [9:0] vcount;
  logic hsync, vsync, hblnk, vblnk, sof;
  logic [15:0] frame_cnt;
  int checks = 0;
  int errors = 0;
  int eh = 0;
  int ev = 0;
  logic [15:0] efc = 16'h0;
  always #5 clk = ~clk;
  vga_timing #(.V_ACTIVE(4), .V_FP(3), .V_SYNC(6), .V_BP(2)) dut (
    .clk(clk), .rst(rst), .ce(ce), .hcount(hcount), .vcount(vcount), .hsync(hsync),
    .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk), .sof(sof), .frame_cnt(frame_cnt)
  );
  function automatic logic [15:0] exp_fc();
    return FC ? efc : 16'h0;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    if (rst && ce) begin
      if (eh == HT - 1) begin
        eh = 0;
        if (ev == VT - 1) begin
          ev = 0;
          efc = efc + 16'd1;
        end else ev++;
      end else eh++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hcount !== 11'd0) begin errors++; $display("FAIL reset_hcount got %0d want 0", hcount); end
    checks++; if (vcount !== 10'd0) begin errors++; $display("FAIL reset_vcount got %0d want 0", vcount); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync); end
    checks++; if (hblnk !== 1'b0) begin errors++; $display("FAIL reset_hblnk got %b want 0", hblnk); end
    checks++; if (vblnk !== 1'b0) begin errors++; $display("FAIL reset_vblnk got %b want 0", vblnk); end
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL reset_sof got %b want 0", sof); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
    rst = 1'b1;
    repeat (5) step();
    checks++; if (hcount !== 11'd5) begin errors++; $display("FAIL release_hcount got %0d want 5", hcount); end
    checks++; if (vcount !== 10'd0) begin errors++; $display("FAIL release_vcount got %0d want 0", vcount); end
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL release_sof got %b want 0", sof); end
  endtask
  task automatic test_line();
    int hlow = 0;
    int hbl = 0;
    for (int i = 0; i < HT; i++) begin
      step();
      checks++; if (hcount !== 11'(eh)) begin errors++; $display("FAIL line_hcount got %0d want %0d", hcount, eh); end
      checks++; if (hsync !== ((eh >= 1048 && eh <= 1183) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL line_hsync at %0d got %b", eh, hsync); end
      checks++; if (hblnk !== (eh >= 1024)) begin errors++; $display("FAIL line_hblnk at %0d got %b", eh, hblnk); end
      if (hsync === 1'b0) hlow++;
      if (hblnk === 1'b1) hbl++;
      if (eh == 0) break;
    end
    checks++; if (hcount !== 11'd0) begin errors++; $display("FAIL line_wrap_hcount got %0d want 0", hcount); end
    checks++; if (vcount !== 10'd1) begin errors++; $display("FAIL line_wrap_vcount got %0d want 1", vcount); end
    checks++; if (hlow != 136) begin errors++; $display("FAIL line_hsync_width got %0d want 136", hlow); end
    checks++; if (hbl != 320) begin errors++; $display("FAIL line_hblnk_width got %0d want 320", hbl); end
  endtask
  task automatic test_frame_wrap();
    int vlow = 0;
    for (int i = 0; i < HT * VT && !(eh == HT - 1 && ev == VT - 1); i++) begin
      step();
      checks++; if (hcount !== 11'(eh) || vcount !== 10'(ev)) begin errors++; $display("FAIL frame_pos got (%0d,%0d) want (%0d,%0d)", hcount, vcount, eh, ev); end
      checks++; if (vsync !== ((ev >= VS0 && ev <= VS1) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL frame_vsync line %0d got %b", ev, vsync); end
      checks++; if (vblnk !== (ev >= VA)) begin errors++; $display("FAIL frame_vblnk line %0d got %b", ev, vblnk); end
      checks++; if (sof !== 1'b0) begin errors++; $display("FAIL frame_sof_spurious at (%0d,%0d) got %b", eh, ev, sof); end
      if (eh == 0 && vsync === 1'b0) vlow++;
    end
    checks++; if (vlow != 6) begin errors++; $display("FAIL frame_vsync_lines got %0d want 6", vlow); end
    step();
    checks++; if (hcount !== 11'd0 || vcount !== 10'd0) begin errors++; $display("FAIL wrap_pos got (%0d,%0d) want (0,0)", hcount, vcount); end
    checks++; if (sof !== 1'b1) begin errors++; $display("FAIL wrap_sof got %b want 1", sof); end
    checks++; if (frame_cnt !== exp_fc()) begin errors++; $display("FAIL wrap_frame_cnt got %h want %h", frame_cnt, exp_fc()); end
    checks++; if (vsync !== 1'b1 || vblnk !== 1'b0) begin errors++; $display("FAIL wrap_v_flags got vsync %b vblnk %b want 1 0", vsync, vblnk); end
    step();
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL wrap_sof_drop got %b want 0", sof); end
  endtask
  task automatic test_enable_hold();
    for (int i = 0; i < HT && eh != 500; i++) step();
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (hcount !== 11'd500 || vcount !== 10'd0) begin errors++; $display("FAIL hold_pos got (%0d,%0d) want (500,0)", hcount, vcount); end
      checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || hblnk !== 1'b0 || vblnk !== 1'b0 || sof !== 1'b0) begin errors++; $display("FAIL hold_flags got %b%b%b%b%b want 11000", hsync, vsync, hblnk, vblnk, sof); end
    end
    ce = 1'b1;
    step();
    checks++; if (hcount !== 11'd501) begin errors++; $display("FAIL hold_resume got %0d want 501", hcount); end
    for (int i = 0; i < HT * VT && !(eh == HT - 1 && ev == VT - 1); i++) step();
    step();
    checks++; if (sof !== 1'b1) begin errors++; $display("FAIL hold_sof_enter got %b want 1", sof); end
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (sof !== 1'b1 || hcount !== 11'd0 || vcount !== 10'd0) begin errors++; $display("FAIL hold_sof got sof %b pos (%0d,%0d) want 1 (0,0)", sof, hcount, vcount); end
      checks++; if (frame_cnt !== exp_fc()) begin errors++; $display("FAIL hold_frame_cnt got %h want %h", frame_cnt, exp_fc()); end
    end
    ce = 1'b1;
    step();
    checks++; if (sof !== 1'b0 || hcount !== 11'd1) begin errors++; $display("FAIL hold_sof_release got sof %b hcount %0d want 0 1", sof, hcount); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < HT * VT && !(eh == 700 && ev == 4); i++) step();
    checks++; if (hcount !== 11'd700 || vcount !== 10'd4 || vblnk !== 1'b1) begin errors++; $display("FAIL areset_pre got (%0d,%0d) vblnk %b want (700,4) 1", hcount, vcount, vblnk); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (hcount !== 11'd0 || vcount !== 10'd0) begin errors++; $display("FAIL areset_pos got (%0d,%0d) want (0,0)", hcount, vcount); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || hblnk !== 1'b0 || vblnk !== 1'b0 || sof !== 1'b0) begin errors++; $display("FAIL areset_flags got %b%b%b%b%b want 11000", hsync, vsync, hblnk, vblnk, sof); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL areset_frame_cnt got %h want 0000", frame_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    eh = 0;
    ev = 0;
    efc = 16'h0;
    step();
    checks++; if (hcount !== 11'd1 || vcount !== 10'd0 || sof !== 1'b0) begin errors++; $display("FAIL areset_restart got (%0d,%0d) sof %b want (1,0) 0", hcount, vcount, sof); end
  endtask
`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_rollover();
    force dut.frame_cnt = 16'hFFFF;
    step();
    release dut.frame_cnt;
    efc = 16'hFFFF;
    for (int i = 0; i < HT * VT && !(eh == HT - 1 && ev == VT - 1); i++) step();
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL roll_pre got %h want ffff", frame_cnt); end
    step();
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL roll_frame_cnt got %h want 0000", frame_cnt); end
    checks++; if (sof !== 1'b1) begin errors++; $display("FAIL roll_sof got %b want 1", sof); end
  endtask
`endif
  initial begin
    test_reset();
    test_line();
    test_frame_wrap();
    test_enable_hold();
    test_async_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_rollover();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
